// File: rtl/axi_dma_burst_sched_if.sv
// Command channel between the burst scheduler and the DMA read/write datapath.
interface axi_dma_burst_sched_if #(
  parameter int unsigned WIDTH_AD = 32
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [WIDTH_AD-1:0] cmd_src;
  logic [WIDTH_AD-1:0] cmd_dst;
  logic [15:0]         cmd_bytes;
  logic [3:0]          cmd_rlen;
  logic [3:0]          cmd_wlen;
  logic                cmd_cmpl;
  logic                cmd_cerr;

  modport master (
    output cmd_valid, cmd_src, cmd_dst, cmd_bytes, cmd_rlen, cmd_wlen,
    input  cmd_ready, cmd_cmpl, cmd_cerr
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst, cmd_bytes, cmd_rlen, cmd_wlen,
    output cmd_ready, cmd_cmpl, cmd_cerr
  );
endinterface

// File: rtl/axi_dma_burst_sched.sv
// Burst scheduler: splits one DMA job into burst commands bounded by chunk
// length, src/dst misalignment and 4KB pages; tracks outstanding commands.
module axi_dma_burst_sched #(
  parameter int unsigned WIDTH_AD  = 32,
  parameter int unsigned WIDTH_DA  = 32,
  parameter int unsigned WIDTH_DS  = WIDTH_DA / 8,
  parameter int unsigned WIDTH_DSB = $clog2(WIDTH_DS),
  parameter int unsigned MAX_OUT   = 4
) (
  input  logic                  ARESETn,
  input  logic                  ACLK,
  input  logic                  job_start,
  input  logic [WIDTH_AD-1:0]   job_src,
  input  logic [WIDTH_AD-1:0]   job_dst,
  input  logic [15:0]           job_bnum,
  input  logic [7:0]            job_chunk,
  output logic                  job_busy,
  output logic                  job_done,
  output logic                  job_err,
  axi_dma_burst_sched_if.master cmd
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN} state_t;

  state_t              state;
  logic [WIDTH_AD-1:0] src_q;
  logic [WIDTH_AD-1:0] dst_q;
  logic [15:0]         rem_q;
  logic [4:0]          chunk_q;
  logic                err_q;
  logic [3:0]          out_q;

  logic [4:0]  chunk_eff;
  logic [16:0] soff, doff, chunk_bytes, lim_s, lim_d, page_s, page_d, bytes_c;
  logic [3:0]  rlen_c, wlen_c, out_nx;
  logic        hs, cmpl_ok, can_issue;

  function automatic logic [16:0] min17(input logic [16:0] a, input logic [16:0] b);
    return (a < b) ? a : b;
  endfunction

  always_comb begin
    chunk_eff   = (job_chunk == 8'd0 || job_chunk > 8'd16) ? 5'd16 : job_chunk[4:0];
    soff        = 17'(src_q[11:0]) & 17'(WIDTH_DS - 1);
    doff        = 17'(dst_q[11:0]) & 17'(WIDTH_DS - 1);
    chunk_bytes = 17'(chunk_q) << WIDTH_DSB;
    lim_s       = chunk_bytes - soff;
    lim_d       = chunk_bytes - doff;
    page_s      = 17'd4096 - 17'(src_q[11:0]);
    page_d      = 17'd4096 - 17'(dst_q[11:0]);
    bytes_c     = min17(min17(17'(rem_q), min17(lim_s, lim_d)), min17(page_s, page_d));
    // beats-1 = ceil((off+bytes)/DS)-1 = (off+bytes-1)/DS, bytes >= 1
    rlen_c      = 4'((soff + bytes_c - 17'd1) >> WIDTH_DSB);
    wlen_c      = 4'((doff + bytes_c - 17'd1) >> WIDTH_DSB);
    hs          = cmd.cmd_valid & cmd.cmd_ready;
    cmpl_ok     = cmd.cmd_cmpl & (out_q != 4'd0);
    out_nx      = out_q + 4'(hs) - 4'(cmpl_ok);
    can_issue   = out_nx < 4'(MAX_OUT);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state         <= S_IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      rem_q         <= '0;
      chunk_q       <= '0;
      err_q         <= 1'b0;
      out_q         <= '0;
      job_busy      <= 1'b0;
      job_done      <= 1'b0;
      job_err       <= 1'b0;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_src   <= '0;
      cmd.cmd_dst   <= '0;
      cmd.cmd_bytes <= '0;
      cmd.cmd_rlen  <= '0;
      cmd.cmd_wlen  <= '0;
    end else begin
      job_done <= 1'b0;
      job_err  <= 1'b0;
      out_q    <= out_nx;
      if (cmpl_ok && cmd.cmd_cerr) err_q <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (job_start) begin
            src_q    <= job_src;
            dst_q    <= job_dst;
            rem_q    <= job_bnum;
            chunk_q  <= chunk_eff;
            err_q    <= 1'b0;
            job_busy <= 1'b1;
            state    <= (job_bnum == 16'd0) ? S_DRAIN : S_CALC;
          end
        end
        S_CALC: begin
          cmd.cmd_src   <= src_q;
          cmd.cmd_dst   <= dst_q;
          cmd.cmd_bytes <= 16'(bytes_c);
          cmd.cmd_rlen  <= rlen_c;
          cmd.cmd_wlen  <= wlen_c;
          cmd.cmd_valid <= can_issue;
          state         <= S_ISSUE;
        end
        S_ISSUE: begin
          if (hs) begin
            src_q         <= src_q + WIDTH_AD'(cmd.cmd_bytes);
            dst_q         <= dst_q + WIDTH_AD'(cmd.cmd_bytes);
            rem_q         <= rem_q - cmd.cmd_bytes;
            cmd.cmd_valid <= 1'b0;
            state         <= (rem_q == cmd.cmd_bytes) ? S_DRAIN : S_CALC;
          end else begin
            // outstanding cannot grow without a handshake, so valid never drops here
            cmd.cmd_valid <= cmd.cmd_valid | can_issue;
          end
        end
        S_DRAIN: begin
          if (out_q == 4'd0) begin
            job_done <= 1'b1;
            job_err  <= err_q;
            job_busy <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
